iir_biquad_cascade: RTL and testbench

//  Parametrised, run-time-programmable IIR filter: NUM_SECT Direct-Form-I biquads in cascade,

---
 rtl/iir_biquad_cascade.sv | 243 ++++++++++++++++++++++++
 tb/tb_iir_biquad_cascade.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: run-time programmable cascade of NUM_SECT Direct-Form-I
// biquads evaluated by one shared five-multiplier section engine, one section
// per clock. Coefficients are written over a small register port; the section
// histories can be zeroed with the synchronous clear input.
// Build option: define IIR_SATURATE_EN to clamp each section output to the
// DATA_W range and raise the sticky sat_flag; otherwise section outputs wrap
// and sat_flag is tied low.
module iir_biquad_cascade #(
    parameter int DATA_W   = 32,
    parameter int COEF_W   = 18,
    parameter int FRAC_W   = 14,
    parameter int NUM_SECT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] y,
    input  logic                     coef_we,
    input  logic [5:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     sat_flag
);

    // Accumulator wide enough for five full products plus growth.
    localparam int ACC_W  = DATA_W + COEF_W + 3;
    localparam int SECT_W = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;
    localparam logic [SECT_W-1:0]       LAST_SECT = SECT_W'(NUM_SECT - 1);
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SECT_W-1:0]        sect;
    logic signed [DATA_W-1:0] u_p1;

    logic signed [COEF_W-1:0] b0 [NUM_SECT];
    logic signed [COEF_W-1:0] b1 [NUM_SECT];
    logic signed [COEF_W-1:0] b2 [NUM_SECT];
    logic signed [COEF_W-1:0] a1 [NUM_SECT];
    logic signed [COEF_W-1:0] a2 [NUM_SECT];

    logic signed [DATA_W-1:0] u1 [NUM_SECT];
    logic signed [DATA_W-1:0] u2 [NUM_SECT];
    logic signed [DATA_W-1:0] v1 [NUM_SECT];
    logic signed [DATA_W-1:0] v2 [NUM_SECT];

    logic accept;
    logic step;
    logic last;

    logic signed [ACC_W-1:0]  acc_p0;
    logic signed [ACC_W-1:0]  shf_p0;
    logic signed [DATA_W-1:0] v_p0;

    // One signed product, both operands sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic signed [COEF_W-1:0] c,
        input logic signed [DATA_W-1:0] d
    );
        logic signed [ACC_W-1:0] ce;
        logic signed [ACC_W-1:0] de;
        ce = ACC_W'(c);
        de = ACC_W'(d);
        return ce * de;
    endfunction

`ifdef IIR_SATURATE_EN
    logic ovf_p0;

    // True when the shifted accumulator does not fit in DATA_W signed bits.
    function automatic logic range_ovf(input logic signed [ACC_W-1:0] s);
        logic [ACC_W-DATA_W:0] top;
        top = s[ACC_W-1:DATA_W-1];
        return !((&top) || !(|top));
    endfunction

    // Narrow to DATA_W, clamping to the most positive / most negative value.
    function automatic logic signed [DATA_W-1:0] sat_narrow(input logic signed [ACC_W-1:0] s);
        if (range_ovf(s)) begin
            return s[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
        return s[DATA_W-1:0];
    endfunction
`else
    logic unused_bits;

    // Narrow to DATA_W by keeping the low bits (two's-complement wrap).
    function automatic logic signed [DATA_W-1:0] wrap_narrow(input logic signed [ACC_W-1:0] s);
        return s[DATA_W-1:0];
    endfunction
`endif

    // Section engine: accumulate the current section, floor-shift, narrow.
    always_comb begin
        acc_p0 = mac_term(b0[sect], u_p1)
               + mac_term(b1[sect], u1[sect])
               + mac_term(b2[sect], u2[sect])
               - mac_term(a1[sect], v1[sect])
               - mac_term(a2[sect], v2[sect]);
        shf_p0 = acc_p0 >>> FRAC_W;
`ifdef IIR_SATURATE_EN
        ovf_p0 = range_ovf(shf_p0);
        v_p0   = sat_narrow(shf_p0);
`else
        v_p0   = wrap_narrow(shf_p0);
`endif
    end

`ifndef IIR_SATURATE_EN
    // Upper bits of the shifted accumulator are discarded when wrapping.
    assign unused_bits = ^shf_p0[ACC_W-1:DATA_W];
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and per-cycle control; clear outranks a new sample.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        last      = (sect == LAST_SECT);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (!clear && in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Section sequencing: latch the sample, then pass each section's output on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sect      <= '0;
            u_p1      <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= step && last;
            if (accept) begin
                u_p1 <= x;
                sect <= '0;
            end else if (step) begin
                u_p1 <= v_p0;
                sect <= last ? '0 : sect + 1'b1;
            end
            if (step && last) begin
                y <= v_p0;
            end
        end
    end

    // Per-section histories: shifted by the engine, zeroed by clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SECT; s++) begin
                u1[s] <= '0;
                u2[s] <= '0;
                v1[s] <= '0;
                v2[s] <= '0;
            end
        end else if (clear) begin
            for (int s = 0; s < NUM_SECT; s++) begin
                u1[s] <= '0;
                u2[s] <= '0;
                v1[s] <= '0;
                v2[s] <= '0;
            end
        end else if (step) begin
            u1[sect] <= u_p1;
            u2[sect] <= u1[sect];
            v1[sect] <= v_p0;
            v2[sect] <= v1[sect];
        end
    end

    // Coefficient bank: pass-through after reset, writable only while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SECT; s++) begin
                b0[s] <= COEF_ONE;
                b1[s] <= '0;
                b2[s] <= '0;
                a1[s] <= '0;
                a2[s] <= '0;
            end
        end else if (in_ready && coef_we) begin
            for (int s = 0; s < NUM_SECT; s++) begin
                if (coef_addr == 6'(5 * s))     b0[s] <= coef_data;
                if (coef_addr == 6'(5 * s + 1)) b1[s] <= coef_data;
                if (coef_addr == 6'(5 * s + 2)) b2[s] <= coef_data;
                if (coef_addr == 6'(5 * s + 3)) a1[s] <= coef_data;
                if (coef_addr == 6'(5 * s + 4)) a2[s] <= coef_data;
            end
        end
    end

`ifdef IIR_SATURATE_EN
    // Sticky saturation flag; a clear wipes it together with the histories.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_flag <= 1'b0;
        end else if (clear) begin
            sat_flag <= 1'b0;
        end else if (step && ovf_p0) begin
            sat_flag <= 1'b1;
        end
    end
`else
    assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Bench for iir_biquad_cascade: table-driven vectors plus hand-written
// sequences, with a queue scoreboard popped on every out_valid pulse.
module tb_iir_biquad_cascade;
    localparam int DATA_W   = 32;
    localparam int COEF_W   = 18;
    localparam int FRAC_W   = 14;
    localparam int NUM_SECT = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x;
    logic                     out_valid;
    logic signed [DATA_W-1:0] y;
    logic                     coef_we;
    logic [5:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     sat_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic signed [DATA_W-1:0] exp_q[$];
    int ov_cyc[$];
    int acc_cyc[$];

    typedef struct {
        int ph;
        int xv;
        int ev;
    } vec_t;
    vec_t tv[8];

    longint mc[5*NUM_SECT];
    longint mu1[NUM_SECT], mu2[NUM_SECT], mv1[NUM_SECT], mv2[NUM_SECT];

    iir_biquad_cascade #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .NUM_SECT(NUM_SECT)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .y(y),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (reset === 1'b1 && in_valid && in_ready === 1'b1) acc_cyc.push_back(cyc);
        if (out_valid === 1'b1) begin
            ov_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else chk("y", y, exp_q.pop_front());
        end
    end

    task automatic send(input int xv, input int ev);
        int n = 0;
        in_valid = 1'b1;
        x = xv;
        while (in_ready !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(ev);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("outputs_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 6'(a);
        coef_data = COEF_W'(d);
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic do_reset_check();
        reset = 1'b0; in_valid = 1'b0; clear = 1'b0; coef_we = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_sat_flag", sat_flag, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic program_phase(input int ph);
        case (ph)
            0: begin
                write_coef(10, 0);
                write_coef(15, 0);
            end
            1: begin
                write_coef(0, 8192);
                write_coef(5, 8192);
            end
            2: begin
                write_coef(0, 16384);
                write_coef(3, -8192);
                write_coef(5, 16384);
                do_clear();
            end
            default: ;
        endcase
    endtask

    task automatic model_step(input int xin, output int yout);
        longint u, acc, v;
        u = xin;
        for (int s = 0; s < NUM_SECT; s++) begin
            acc = mc[5*s]*u + mc[5*s+1]*mu1[s] + mc[5*s+2]*mu2[s]
                - mc[5*s+3]*mv1[s] - mc[5*s+4]*mv2[s];
            v = acc >>> FRAC_W;
`ifdef IIR_SATURATE_EN
            if (v > 64'sd2147483647) v = 64'sd2147483647;
            else if (v < -64'sd2147483648) v = -64'sd2147483648;
`else
            v = longint'(int'(v));
`endif
            mu2[s] = mu1[s]; mu1[s] = u;
            mv2[s] = mv1[s]; mv1[s] = v;
            u = v;
        end
        yout = int'(u);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc[10];
        int e;
        int xs[5];
        logic signed [DATA_W-1:0] sat_exp;

        tv[0] = '{0, 1000, 1000};
        tv[1] = '{0, -7, -7};
        tv[2] = '{1, 4096, 1024};
        tv[3] = '{1, -3, -1};
        tv[4] = '{2, 16384, 16384};
        tv[5] = '{2, 0, 8192};
        tv[6] = '{2, 0, 4096};
        tv[7] = '{2, 0, 2048};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; x = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        @(posedge clk); #1;
        do_reset_check();

        // Pass-through, gain and recursion vectors.
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || tv[i].ph != tv[i-1].ph) begin
                if (i != 0) drain();
                program_phase(tv[i].ph);
            end
            send(tv[i].xv, tv[i].ev);
        end
        drain();
        if (acc_cyc.size() > 0 && ov_cyc.size() > 0) chk("latency", ov_cyc[0] - acc_cyc[0], 3);
        else chk("latency_seen", 0, 1);

        // Clear mid-pass aborts without out_valid; y holds; histories zeroed.
        send(777, 0);
        exp_q.delete();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("clear_abort_y_held", y, 2048);
        send(0, 0);
        drain();

        // Back-to-back handshake with an ignored coefficient write during RUN.
        do_reset_check();
        acc_cyc.delete();
        ov_cyc.delete();
        xs = '{11, -22, 33, -44, 55};
        fork
            begin
                for (int i = 0; i < 5; i++) send(xs[i], xs[i]);
            end
            begin
                int n = 0;
                while (in_ready !== 1'b0 && n < 20) begin
                    @(posedge clk); #1;
                    n++;
                end
                coef_we = 1'b1; coef_addr = 6'd0; coef_data = '0;
                @(posedge clk); #1;
                coef_we = 1'b0;
            end
        join
        drain();
        chk("hs_accepts", acc_cyc.size(), 5);
        chk("hs_pulses", ov_cyc.size(), 5);
        if (acc_cyc.size() == 5 && ov_cyc.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("hs_latency", ov_cyc[i] - acc_cyc[i], 3);
            for (int i = 1; i < 5; i++) chk("hs_accept_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
            for (int i = 1; i < 5; i++) chk("hs_pulse_spacing", ov_cyc[i] - ov_cyc[i-1], 3);
        end

        // Saturation versus wrap with gain 4.0 in both sections.
        write_coef(0, 65536);
        write_coef(5, 65536);
`ifdef IIR_SATURATE_EN
        sat_exp = 32'h7FFF_FFFF;
        send(32'h3000_0000, sat_exp);
        drain();
        chk("sat_flag_set", sat_flag, 1);
`else
        sat_exp = 32'h0000_0000;
        send(32'h3000_0000, sat_exp);
        drain();
        chk("sat_flag_low", sat_flag, 0);
`endif
        do_clear();
        chk("sat_flag_after_clear", sat_flag, 0);

        // Reset in the middle of a pass.
        send(1234, 0);
        exp_q.delete();
        reset = 1'b0;
        #1;
        chk("midrun_in_ready", in_ready, 1);
        chk("midrun_out_valid", out_valid, 0);
        chk("midrun_y", y, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send(5, 5);
        drain();

        // General coefficients against the reference model.
        rc = '{4096, 8192, 4096, -6000, 2000, 16384, -3000, 1000, 3000, -1000};
        for (int k = 0; k < 10; k++) begin
            write_coef(k, rc[k]);
            mc[k] = rc[k];
        end
        do_clear();
        for (int s = 0; s < NUM_SECT; s++) begin
            mu1[s] = 0; mu2[s] = 0; mv1[s] = 0; mv2[s] = 0;
        end
        for (int i = 0; i < 20; i++) begin
            int xv;
            xv = int'($urandom_range(0, 2000000)) - 1000000;
            model_step(xv, e);
            send(xv, e);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
